switch_box_cfg: RTL and testbench



---
 rtl/switch_box_cfg_if.sv | 32 +++
 rtl/switch_box_cfg.sv | 110 +++++++++++
 tb/tb_switch_box_cfg.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_box_cfg_if.sv
// Bundles the serial configuration port and the four track buses of a switch box.
//   master : configuration/fabric driver side (drives config_* and *_in)
//   slave  : switch box side (drives config_out, cfg_valid, cfg_err and *_out)
// Only config_clk and config_rst_n stay outside the bundle, as plain module ports.
interface switch_box_cfg_if #(
  parameter int unsigned WIDTH = 2
);
  logic             config_in;
  logic             config_en;
  logic             config_commit;
  logic             config_out;
  logic             cfg_valid;
  logic             cfg_err;
  logic [WIDTH-1:0] l_in;
  logic [WIDTH-1:0] t_in;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] l_out;
  logic [WIDTH-1:0] t_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] b_out;

  modport master (
    output config_in, config_en, config_commit, l_in, t_in, r_in, b_in,
    input  config_out, cfg_valid, cfg_err, l_out, t_out, r_out, b_out
  );

  modport slave (
    input  config_in, config_en, config_commit, l_in, t_in, r_in, b_in,
    output config_out, cfg_valid, cfg_err, l_out, t_out, r_out, b_out
  );
endinterface

// File: rtl/switch_box_cfg.sv
// Double-buffered programmable routing switch box.
// Each output track on each side is a 4:1 mux choosing constant 0 or the matching track
// of one of the other three sides. Select bits are shifted serially into a shadow chain,
// then copied atomically to the active register on a commit that carries exactly
// 8*WIDTH shifted bits; other commits are rejected and flagged on cfg_err.
// Ports:
//   config_clk    : clock for all state, rising edge
//   config_rst_n  : asynchronous active-low reset
//   cfg_bus       : slave side of switch_box_cfg_if
//                   config_in/en/commit, config_out (chain MSB), cfg_valid, cfg_err,
//                   l/t/r/b_in and l/t/r/b_out track buses
// TOPOLOGY: 0 = disjoint (all connections on track i); 1 = Wilton (turns use track i+1).
module switch_box_cfg #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned TOPOLOGY = 0
) (
  input  logic            config_clk,
  input  logic            config_rst_n,
  switch_box_cfg_if.slave cfg_bus
);

  localparam int unsigned CfgBits = 8 * WIDTH;
  localparam int unsigned CntW    = $clog2(CfgBits + 2);

  logic [CfgBits-1:0] chain_q, chain_d;
  logic [CfgBits-1:0] active_q, active_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  // Source track for a turning connection; straight connections always use track i.
  function automatic int unsigned turn_idx(input int unsigned i);
    if (TOPOLOGY == 1) return (i + 1) % WIDTH;
    return i;
  endfunction

  function automatic logic mux4(input logic [1:0] sel, input logic a, input logic b,
                                input logic c);
    case (sel)
      2'd0:    return 1'b0;
      2'd1:    return a;
      2'd2:    return b;
      default: return c;
    endcase
  endfunction

  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (cfg_bus.config_commit) begin
      // Commit wins over shift; the chain is kept intact so it can still be read back.
      if (cnt_q == CntW'(CfgBits)) begin
        active_d = chain_q;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      cnt_d = '0;
    end else if (cfg_bus.config_en) begin
      chain_d = {chain_q[CfgBits-2:0], cfg_bus.config_in};
      // Saturate one past full so an overfilled chain is still distinguishable.
      if (cnt_q != CntW'(CfgBits + 1)) cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      chain_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign cfg_bus.config_out = chain_q[CfgBits-1];
  assign cfg_bus.cfg_valid  = valid_q;
  assign cfg_bus.cfg_err    = err_q;

  // Mux m = 4*track + side (L=0, T=1, R=2, B=3) uses active_q[2m+1:2m].
  always_comb begin
    cfg_bus.l_out = '0;
    cfg_bus.t_out = '0;
    cfg_bus.r_out = '0;
    cfg_bus.b_out = '0;
    if (valid_q) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cfg_bus.l_out[i] = mux4(active_q[2*(4*i+0) +: 2], cfg_bus.t_in[turn_idx(i)],
                                cfg_bus.r_in[i], cfg_bus.b_in[turn_idx(i)]);
        cfg_bus.t_out[i] = mux4(active_q[2*(4*i+1) +: 2], cfg_bus.l_in[turn_idx(i)],
                                cfg_bus.r_in[turn_idx(i)], cfg_bus.b_in[i]);
        cfg_bus.r_out[i] = mux4(active_q[2*(4*i+2) +: 2], cfg_bus.l_in[i],
                                cfg_bus.t_in[turn_idx(i)], cfg_bus.b_in[turn_idx(i)]);
        cfg_bus.b_out[i] = mux4(active_q[2*(4*i+3) +: 2], cfg_bus.l_in[turn_idx(i)],
                                cfg_bus.t_in[i], cfg_bus.r_in[turn_idx(i)]);
      end
    end
  end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Self-checking bench: two switch boxes (disjoint and Wilton, WIDTH=2) share one stimulus
// stream and are compared every cycle against a behavioural model, plus literal checks.
module tb_switch_box_cfg;
  localparam int unsigned W = 2;
  localparam int unsigned NB = 8 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_in = 1'b0, cfg_en = 1'b0, cfg_commit = 1'b0;
  logic [W-1:0] l_in = '0, t_in = '0, r_in = '0, b_in = '0;
  bit chk_on = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  switch_box_cfg_if #(.WIDTH(W)) if0 ();
  switch_box_cfg_if #(.WIDTH(W)) if1 ();

  assign if0.config_in = cfg_in;     assign if1.config_in = cfg_in;
  assign if0.config_en = cfg_en;     assign if1.config_en = cfg_en;
  assign if0.config_commit = cfg_commit; assign if1.config_commit = cfg_commit;
  assign if0.l_in = l_in; assign if0.t_in = t_in; assign if0.r_in = r_in; assign if0.b_in = b_in;
  assign if1.l_in = l_in; assign if1.t_in = t_in; assign if1.r_in = r_in; assign if1.b_in = b_in;

  switch_box_cfg #(.WIDTH(W), .TOPOLOGY(0)) dut0 (
    .config_clk(clk), .config_rst_n(rst_n), .cfg_bus(if0)
  );
  switch_box_cfg #(.WIDTH(W), .TOPOLOGY(1)) dut1 (
    .config_clk(clk), .config_rst_n(rst_n), .cfg_bus(if1)
  );

  // ---------------- behavioural model ----------------
  logic m_q[$];          // m_q[0] is the oldest bit still in the chain (chain MSB)
  int   m_shifted;       // bits shifted since last commit/reset (unsaturated)
  int   m_sel [4][W];    // active select per [side][track]
  bit   m_valid, m_err;

  function automatic void model_reset();
    m_q = {};
    for (int k = 0; k < NB; k++) m_q.push_back(1'b0);
    m_shifted = 0;
    m_valid = 1'b0;
    m_err = 1'b0;
    for (int s = 0; s < 4; s++) for (int t = 0; t < W; t++) m_sel[s][t] = 0;
  endfunction

  function automatic void model_clock(logic din, logic en, logic com);
    if (com) begin
      if (m_shifted == NB) begin
        // Mux m's select is {chain[2m+1], chain[2m]}; chain[j] is m_q[NB-1-j].
        for (int m = 0; m < 4 * W; m++)
          m_sel[m % 4][m / 4] = 2 * int'(m_q[NB-2-2*m]) + int'(m_q[NB-1-2*m]);
        m_valid = 1'b1;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_shifted = 0;
    end else if (en) begin
      m_q.push_back(din);
      void'(m_q.pop_front());
      m_shifted++;
    end
  endfunction

  function automatic logic in_bit(int side, int trk);
    case (side)
      0: return l_in[trk];
      1: return t_in[trk];
      2: return r_in[trk];
      default: return b_in[trk];
    endcase
  endfunction

  // Select s picks the s-th of the other three sides in L,T,R,B order. Sides two apart
  // are straight-through; otherwise it's a turn, which Wilton shifts to track+1.
  function automatic logic exp_out(int topo, int side, int trk);
    int s, src, n, st;
    if (!m_valid) return 1'b0;
    s = m_sel[side][trk];
    if (s == 0) return 1'b0;
    n = 0;
    src = 0;
    for (int k = 0; k < 4; k++) if (k != side) begin n++; if (n == s) src = k; end
    st = trk;
    if (topo == 1 && ((src - side) % 2 != 0)) st = (trk + 1) % W;
    return in_bit(src, st);
  endfunction

  function automatic logic [4*W+2:0] exp_vec(int topo);
    logic [4*W-1:0] o;
    for (int s = 0; s < 4; s++) for (int t = 0; t < W; t++) o[s*W+t] = exp_out(topo, s, t);
    return {m_q[0], m_valid, m_err, o};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [4*W+2:0] g0, g1, e0, e1;
      g0 = {if0.config_out, if0.cfg_valid, if0.cfg_err, if0.b_out, if0.r_out, if0.t_out,
            if0.l_out};
      g1 = {if1.config_out, if1.cfg_valid, if1.cfg_err, if1.b_out, if1.r_out, if1.t_out,
            if1.l_out};
      e0 = exp_vec(0);
      e1 = exp_vec(1);
      n_cmp += 2;
      if (g0 !== e0) begin
        n_bad++;
        $display("FAIL model_topo0 t=%0t got=%b exp=%b", $time, g0, e0);
      end
      if (g1 !== e1) begin
        n_bad++;
        $display("FAIL model_topo1 t=%0t got=%b exp=%b", $time, g1, e1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at posedge+1; applies inputs, clocks once, returns at next posedge+1.
  task automatic cyc(input logic din, input logic en, input logic com);
    cfg_in = din;
    cfg_en = en;
    cfg_commit = com;
    l_in = W'($urandom);
    t_in = W'($urandom);
    r_in = W'($urandom);
    b_in = W'($urandom);
    @(posedge clk);
    if (rst_n) model_clock(din, en, com);
    #1;
  endtask

  task automatic load(input logic [15:0] word, input int nbits, input bit commit);
    for (int k = nbits - 1; k >= 0; k--) cyc(word[k], 1'b1, 1'b0);
    if (commit) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    pin("reset_zero", {if0.config_out, if0.cfg_valid, if0.cfg_err, if0.l_out, if0.t_out,
                        if0.r_out, if0.b_out, if1.l_out, if1.t_out, if1.r_out, if1.b_out}, 0);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] pat;
    model_reset();
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    pin("por_flags", {if0.config_out, if0.cfg_valid, if0.cfg_err}, 0);
    rst_n = 1'b1;

    // mux0 (L track 0) sel=2 -> l_out[0] = r_in[0]
    load(16'h0002, 16, 1'b1);
    pin("load1_flags", {if0.cfg_valid, if0.cfg_err}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      pin("l0_follows_r0", if0.l_out[0], r_in[0]);
      pin("others_zero", {if0.l_out[1], if0.t_out, if0.r_out, if0.b_out}, 0);
    end

    // Under-fill rejected, previous routing kept
    load(16'h0080, 15, 1'b1);
    pin("underfill_flags", {if0.cfg_valid, if0.cfg_err}, 2'b11);
    pin("underfill_keep", if0.l_out[0], r_in[0]);
    load(16'h0080, 16, 1'b1);
    pin("refill_flags", {if0.cfg_valid, if0.cfg_err}, 2'b10);
    pin("b0_follows_t0", {if0.b_out[0], if0.l_out}, {t_in[0], 2'b00});

    // Readback of 0xA5C3 MSB-first while routing holds, then overflow
    load(16'hA5C3, 16, 1'b1);
    pat = 16'hA5C3;
    for (int k = 15; k >= 0; k--) begin
      pin("readback_bit", if0.config_out, pat[k]);
      cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    pin("overflow_flags", {if0.cfg_valid, if0.cfg_err}, 2'b11);

    // Wilton: L0 sel=1 -> t_in[1]; B1 sel=1 -> l_in[0]
    load(16'h4001, 16, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    pin("wilton_l0", if1.l_out[0], t_in[1]);
    pin("wilton_b1_wrap", if1.b_out[1], l_in[0]);
    pin("disjoint_l0", if0.l_out[0], t_in[0]);
    load(16'h0002, 16, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    pin("wilton_l0_straight", if1.l_out[0], r_in[0]);

    // Reset aborts a half load; a full load afterwards succeeds
    load(16'hFFFF, 8, 1'b0);
    do_reset();
    load(16'h1234, 16, 1'b1);
    pin("post_reset_load", {if0.cfg_valid, if0.cfg_err}, 2'b10);

    // Commit and shift together: commit the un-shifted chain
    load(16'hC000, 16, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    pin("en_commit_flags", {if0.cfg_valid, if0.cfg_err, if0.config_out}, 3'b101);
    pin("en_commit_b1", if0.b_out[1], r_in[1]);

    // Randomized phase
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    load(16'($urandom), 16, 1'b1);
        2, 3, 4: cyc(1'($urandom), 1'b1, 1'b0);
        5:       cyc(1'b0, 1'b0, 1'b1);
        6:       cyc(1'($urandom), 1'b1, 1'b1);
        7:       load(16'($urandom), $urandom_range(14, 18), 1'b1);
        8:       cyc(1'($urandom), 1'b0, 1'b0);
        default: if ($urandom_range(0, 9) == 0) do_reset(); else cyc(1'b0, 1'b0, 1'b0);
      endcase
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
